// File: rtl/text_console_writer.sv
// text_console_writer: writer-side engine for the character/attribute text buffer.
// Turns a byte stream into buffer writes (char region at 0, attr region at WIDTH*HEIGHT),
// tracks the cursor, interprets CR/BS/LF/FF, scrolls by copying rows up through the
// buffer read port and clears the screen.
//
// Ports:
//   clk, reset           posedge clock, asynchronous active-high reset
//   in_valid/in_ready    byte handshake; in_data/in_attr sampled on acceptance
//   busy                 FSM not idle
//   cursor_col/row       current cursor position
//   we, oe, addr, di     registered buffer write/read controls
//   dout                 buffer read data, valid at the edge ending an oe cycle
module text_console_writer #(
  parameter int unsigned WIDTH  = 20,
  parameter int unsigned HEIGHT = 15,
  parameter int unsigned AW     = $clog2(WIDTH*HEIGHT) + 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic [7:0]                in_data,
  input  logic [7:0]                in_attr,
  output logic                      in_ready,
  output logic                      busy,
  output logic [$clog2(WIDTH)-1:0]  cursor_col,
  output logic [$clog2(HEIGHT)-1:0] cursor_row,
  output logic                      we,
  output logic                      oe,
  output logic [AW-1:0]             addr,
  output logic [7:0]                di,
  input  logic [7:0]                dout
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam int unsigned RW = $clog2(HEIGHT);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_PUT_C     = 3'd1;
  localparam logic [2:0] S_PUT_A     = 3'd2;
  localparam logic [2:0] S_SCROLL_RD = 3'd3;
  localparam logic [2:0] S_SCROLL_WR = 3'd4;
  localparam logic [2:0] S_FILL      = 3'd5;

  localparam logic [7:0]    SPACE          = 8'h20;
  localparam logic [CW-1:0] COL_MAX        = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_MAX        = RW'(HEIGHT - 1);
  localparam logic [AW-1:0] CELLS          = AW'(WIDTH * HEIGHT);
  localparam logic [AW-1:0] W_A            = AW'(WIDTH);
  localparam logic [AW-1:0] CHAR_COPY_LAST = AW'((HEIGHT - 1) * WIDTH - 1);
  localparam logic [AW-1:0] ATTR_COPY_LAST = AW'(WIDTH * HEIGHT + (HEIGHT - 1) * WIDTH - 1);
  localparam logic [AW-1:0] CHAR_LAST      = AW'(WIDTH * HEIGHT - 1);
  localparam logic [AW-1:0] ALL_LAST       = AW'(2 * WIDTH * HEIGHT - 1);
  localparam logic [AW-1:0] LAST_ROW       = AW'((HEIGHT - 1) * WIDTH);
  localparam logic [AW-1:0] ATTR_LAST_ROW  = AW'(WIDTH * HEIGHT + (HEIGHT - 1) * WIDTH);

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [AW-1:0] ptr_q, ptr_d;     // destination address of the current copy/fill write
  logic          mode_q, mode_d;   // FILL mode: 1 = full clear, 0 = last-row fill after scroll
  logic [7:0]    attr_q, attr_d;
  logic          we_d, oe_d;
  logic [AW-1:0] addr_d;
  logic [7:0]    di_d;
  logic          start_scroll;
  logic [AW-1:0] cpos, fill_next;

  assign cpos       = AW'(row_q) * W_A + AW'(col_q);
  assign in_ready   = (state_q == S_IDLE) && !reset;
  assign busy       = (state_q != S_IDLE);
  assign cursor_col = col_q;
  assign cursor_row = row_q;

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    ptr_d        = ptr_q;
    mode_d       = mode_q;
    attr_d       = attr_q;
    we_d         = 1'b0;
    oe_d         = 1'b0;
    addr_d       = addr;
    di_d         = di;
    start_scroll = 1'b0;
    fill_next    = '0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          attr_d = in_attr;
          case (in_data)
            8'h0D: col_d = '0;
            8'h08: if (col_q != '0) col_d = col_q - 1'b1;
            8'h0A: begin
              col_d = '0;
              if (row_q == ROW_MAX) start_scroll = 1'b1;
              else row_d = row_q + 1'b1;
            end
            8'h0C: begin
              state_d = S_FILL;
              mode_d  = 1'b1;
              ptr_d   = '0;
              we_d    = 1'b1;
              addr_d  = '0;
              di_d    = SPACE;
            end
            default: begin
              state_d = S_PUT_C;
              we_d    = 1'b1;
              addr_d  = cpos;
              di_d    = in_data;
            end
          endcase
        end
      end
      S_PUT_C: begin
        state_d = S_PUT_A;
        we_d    = 1'b1;
        addr_d  = cpos + CELLS;
        di_d    = attr_q;
      end
      S_PUT_A: begin
        state_d = S_IDLE;
        if (col_q == COL_MAX) begin
          col_d = '0;
          if (row_q == ROW_MAX) start_scroll = 1'b1;
          else row_d = row_q + 1'b1;
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      S_SCROLL_RD: begin
        state_d = S_SCROLL_WR;
        we_d    = 1'b1;
        addr_d  = ptr_q;
        di_d    = dout;
      end
      S_SCROLL_WR: begin
        if (ptr_q == ATTR_COPY_LAST) begin
          state_d = S_FILL;
          mode_d  = 1'b0;
          ptr_d   = LAST_ROW;
          we_d    = 1'b1;
          addr_d  = LAST_ROW;
          di_d    = SPACE;
        end else begin
          // Char region done: continue with the attr region one screen further on.
          ptr_d   = (ptr_q == CHAR_COPY_LAST) ? CELLS : ptr_q + 1'b1;
          state_d = S_SCROLL_RD;
          oe_d    = 1'b1;
          addr_d  = ptr_d + W_A;
        end
      end
      S_FILL: begin
        if (ptr_q == ALL_LAST) begin
          state_d = S_IDLE;
          if (mode_q) begin
            col_d = '0;
            row_d = '0;
          end
        end else begin
          // Last-row fill jumps from the char row straight to the matching attr row.
          fill_next = (!mode_q && ptr_q == CHAR_LAST) ? ATTR_LAST_ROW : ptr_q + 1'b1;
          ptr_d     = fill_next;
          we_d      = 1'b1;
          addr_d    = fill_next;
          di_d      = (fill_next < CELLS) ? SPACE : attr_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (start_scroll) begin
      state_d = S_SCROLL_RD;
      oe_d    = 1'b1;
      ptr_d   = '0;
      addr_d  = W_A;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      ptr_q   <= '0;
      mode_q  <= 1'b0;
      attr_q  <= '0;
      we      <= 1'b0;
      oe      <= 1'b0;
      addr    <= '0;
      di      <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      ptr_q   <= ptr_d;
      mode_q  <= mode_d;
      attr_q  <= attr_d;
      we      <= we_d;
      oe      <= oe_d;
      addr    <= addr_d;
      di      <= di_d;
    end
  end

endmodule

// File: tb/tb_text_console_writer.sv
// tb_text_console_writer: directed self-checking bench for text_console_writer with a
// behavioural 2*WIDTH*HEIGHT byte buffer (synchronous write, combinational read).
module tb_text_console_writer;

  localparam int unsigned WIDTH  = 20;
  localparam int unsigned HEIGHT = 15;
  localparam int unsigned AW     = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic [7:0]    in_attr = 8'h00;
  logic          in_ready, busy, we, oe;
  logic [4:0]    cursor_col;
  logic [3:0]    cursor_row;
  logic [AW-1:0] addr;
  logic [7:0]    di, dout;

  logic [7:0] mem [0:1023];
  logic       pl_go = 1'b0;
  int         we_cnt = 0;
  int         oe_cnt = 0;
  int         conflicts = 0;
  int         n_checks = 0;
  int         n_fail = 0;

  text_console_writer #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .AW(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_attr    (in_attr),
    .in_ready   (in_ready),
    .busy       (busy),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .we         (we),
    .oe         (oe),
    .addr       (addr),
    .di         (di),
    .dout       (dout)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pat(input int i);
    return 8'(i * 7 + 3);
  endfunction

  assign dout = mem[addr];

  always @(posedge clk) begin
    if (pl_go) begin
      for (int i = 0; i < 1024; i++) mem[i] <= pat(i);
    end else if (we) begin
      mem[addr] <= di;
    end
    if (we) we_cnt <= we_cnt + 1;
    if (oe) oe_cnt <= oe_cnt + 1;
    if (we && oe) conflicts <= conflicts + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Returns #1 after the acceptance edge, i.e. inside cycle A+1.
  task automatic send(input logic [7:0] d, input logic [7:0] a);
    int g;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_attr  = a;
    g = 0;
    while (!in_ready && g < 5000) begin
      @(negedge clk);
      g++;
    end
    if (g >= 5000) check("send_timeout", {31'd0, in_ready}, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    @(negedge clk);
    while (busy && g < 5000) begin
      @(negedge clk);
      g++;
    end
    if (g >= 5000) check("idle_timeout", {31'd0, busy}, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad, cnt, w0, o0, k, g;
    logic acc;
    logic [7:0] seq [8];
    logic [7:0] exp_di;

    // Reset state
    #3;
    check("rst_in_ready", {31'd0, in_ready}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_we_oe", {30'd0, we, oe}, 0);
    check("rst_addr_di", {14'd0, addr, di}, 0);
    check("rst_cursor", {23'd0, cursor_col, cursor_row}, 0);
    do_reset();

    // Test 1: single printable character
    send(8'h41, 8'h1F);
    check("t1_putc", {13'd0, we, oe, addr, di}, {13'd0, 1'b1, 1'b0, 10'd0, 8'h41});
    @(posedge clk); #1;
    check("t1_puta", {13'd0, we, oe, addr, di}, {13'd0, 1'b1, 1'b0, 10'd300, 8'h1F});
    @(posedge clk); #1;
    check("t1_ready", {30'd0, in_ready, we}, {30'd0, 1'b1, 1'b0});
    check("t1_cursor", {23'd0, cursor_col, cursor_row}, {23'd0, 5'd1, 4'd0});
    send(8'h08, 8'h00);
    check("t1_bs_col", {27'd0, cursor_col}, 0);

    // Test 2: full row wraps to the next row; CR and BS at column 0
    do_reset();
    for (int i = 0; i < 20; i++) send(8'(8'h61 + i), 8'(8'h20 + i));
    wait_idle();
    check("t2_char19", {24'd0, mem[19]}, 8'h74);
    check("t2_attr319", {24'd0, mem[319]}, 8'h33);
    check("t2_cursor", {23'd0, cursor_col, cursor_row}, {23'd0, 5'd0, 4'd1});
    w0 = we_cnt;
    o0 = oe_cnt;
    send(8'h0D, 8'h00);
    send(8'h08, 8'h00);
    repeat (2) @(negedge clk);
    check("t2_cr_bs_cursor", {23'd0, cursor_col, cursor_row}, {23'd0, 5'd0, 4'd1});
    check("t2_no_bus", we_cnt + oe_cnt, w0 + o0);

    // Test 3: LF on the last row scrolls the screen
    do_reset();
    for (int i = 0; i < 14; i++) send(8'h0A, 8'h00);
    for (int i = 0; i < 5; i++) send(8'h78, 8'h00);
    wait_idle();
    check("t3_pos", {23'd0, cursor_col, cursor_row}, {23'd0, 5'd5, 4'd14});
    @(negedge clk);
    pl_go = 1'b1;
    @(negedge clk);
    pl_go = 1'b0;
    send(8'h0A, 8'h4E);
    cnt = 0;
    while (busy && cnt < 3000) begin
      cnt++;
      @(posedge clk); #1;
    end
    check("t3_busy_cycles", cnt, 1160);
    bad = 0;
    for (int n = 0; n < 280; n++) if (mem[n] !== pat(n + 20)) bad++;
    check("t3_char_copy_bad", bad, 0);
    bad = 0;
    for (int n = 0; n < 280; n++) if (mem[300 + n] !== pat(320 + n)) bad++;
    check("t3_attr_copy_bad", bad, 0);
    bad = 0;
    for (int n = 280; n < 300; n++) if (mem[n] !== 8'h20) bad++;
    check("t3_char_fill_bad", bad, 0);
    bad = 0;
    for (int n = 580; n < 600; n++) if (mem[n] !== 8'h4E) bad++;
    check("t3_attr_fill_bad", bad, 0);
    check("t3_cursor", {23'd0, cursor_col, cursor_row}, {23'd0, 5'd0, 4'd14});

    // Test 4: clear screen
    w0 = we_cnt;
    send(8'h0C, 8'h07);
    bad = 0;
    for (int i = 0; i < 600; i++) begin
      exp_di = (i < 300) ? 8'h20 : 8'h07;
      if (!(we === 1'b1 && oe === 1'b0 && addr === 10'(i) && di === exp_di && in_ready === 1'b0))
        bad++;
      @(posedge clk); #1;
    end
    check("t4_clear_seq_bad", bad, 0);
    check("t4_done", {29'd0, we, in_ready, busy}, {29'd0, 1'b0, 1'b1, 1'b0});
    check("t4_we_pulses", we_cnt - w0, 600);
    check("t4_cursor", {23'd0, cursor_col, cursor_row}, 0);

    // Test 5: reset in the middle of a scroll
    for (int i = 0; i < 14; i++) send(8'h0A, 8'h00);
    send(8'h0A, 8'h00);
    repeat (300) @(posedge clk);
    #1;
    check("t5_active", {30'd0, busy, we | oe}, {30'd0, 1'b1, 1'b1});
    #2;
    reset = 1'b1;
    #1;
    check("t5_async_drop", {29'd0, we, oe, busy}, 0);
    check("t5_cursor", {23'd0, cursor_col, cursor_row}, 0);
    check("t5_ready_in_reset", {31'd0, in_ready}, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("t5_ready_after", {31'd0, in_ready}, 1);
    send(8'h5A, 8'h11);
    check("t5_first_write", {13'd0, we, oe, addr, di}, {13'd0, 1'b1, 1'b0, 10'd0, 8'h5A});
    wait_idle();

    // Test 6: in_valid held high with back-to-back bytes
    do_reset();
    seq = '{8'h48, 8'h69, 8'h0D, 8'h4A, 8'h0A, 8'h4B, 8'h08, 8'h4C};
    w0 = we_cnt;
    @(negedge clk);
    k = 0;
    in_valid = 1'b1;
    in_data  = seq[0];
    in_attr  = 8'h30;
    for (g = 0; g < 200 && k < 8; g++) begin
      acc = in_ready;
      @(negedge clk);
      if (acc) begin
        k++;
        if (k < 8) begin
          in_data = seq[k];
          in_attr = 8'(8'h30 + k);
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid = 1'b0;
    wait_idle();
    check("t6_accepted", k, 8);
    check("t6_mem0", {24'd0, mem[0]}, 8'h4A);
    check("t6_mem1", {24'd0, mem[1]}, 8'h69);
    check("t6_mem20", {24'd0, mem[20]}, 8'h4C);
    check("t6_attr300", {24'd0, mem[300]}, 8'h33);
    check("t6_attr301", {24'd0, mem[301]}, 8'h31);
    check("t6_attr320", {24'd0, mem[320]}, 8'h37);
    check("t6_cursor", {23'd0, cursor_col, cursor_row}, {23'd0, 5'd1, 4'd1});
    check("t6_we_pulses", we_cnt - w0, 10);
    check("we_oe_conflicts", conflicts, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/text_console_writer.md
Name: text_console_writer

Overview:
Writer-side engine for the character/attribute text buffer. It accepts a stream of ASCII bytes with a valid/ready handshake and turns each byte into buffer writes: the character into the char region and the current attribute into the attr region. It tracks a cursor, interprets control codes, scrolls the screen by copying rows up through the buffer's read port, and clears the screen. It sits between the CPU/UART byte source and the buffer's we/oe/addr/di/dout port.

Parameters:
WIDTH, 20, text columns; must match the buffer.
HEIGHT, 15, text rows; must match the buffer.
AW, $clog2(WIDTH*HEIGHT)+1, buffer address width. The attr region starts at WIDTH*HEIGHT.

Ports:
clk  in  1  system clock, posedge.
reset  in  1  asynchronous, active-high reset.
in_valid  in  1  byte available.
in_data  in  8  ASCII byte.
in_attr  in  8  attribute for this byte (fg [3:0], bg [7:4]); sampled with in_data.
in_ready  out  1  block can accept a byte.
busy  out  1  FSM not in IDLE.
cursor_col  out  $clog2(WIDTH)  current column.
cursor_row  out  $clog2(HEIGHT)  current row.
we  out  1  buffer write enable.
oe  out  1  buffer read enable.
addr  out  AW  buffer address.
di  out  8  buffer write data.
dout  in  8  buffer read data; valid at the posedge following the cycle oe was high.

Behaviour:
- Reset (async): state IDLE, cursor (0,0), we=oe=0, addr=0, di=0, busy=0, in_ready=0 while reset is high. Reset mid-operation aborts at once; buffer contents are left as they are.
- in_ready = (state==IDLE). A byte is accepted on a posedge with in_valid & in_ready; in_data and in_attr are latched at that edge.
- All buffer outputs are registered. Bus activity starts in the cycle after acceptance, called A+1.
- cpos = row*WIDTH + col; apos = WIDTH*HEIGHT + cpos.
- Printable byte (not 0x08/0x0A/0x0C/0x0D):
  - A+1, PUT_C: we=1, addr=cpos, di=byte.
  - A+2, PUT_A: we=1, addr=apos, di=attr.
  - Cursor then advances: col+1. At col==WIDTH-1: col=0, row+1. At row==HEIGHT-1 this instead starts a SCROLL and row stays HEIGHT-1.
  - Returns to IDLE at A+3 (3 cycles per character when no scroll).
- 0x0D: col=0, no bus traffic, IDLE at A+1.
- 0x08: col-1 if col>0, else no-op (no reverse wrap); nothing is erased.
- 0x0A: col=0, row+1. On the last row this triggers SCROLL.
- 0x0C (clear screen):
  - FILL every char cell with 0x20, then every attr cell with the latched attr, one write per cycle, addr ascending 0..2*WIDTH*HEIGHT-1.
  - Cursor (0,0) afterwards.
  - Takes 2*WIDTH*HEIGHT cycles.
- SCROLL, for n=0..(HEIGHT-1)*WIDTH-1, char region first, then the same for the attr region (offset WIDTH*HEIGHT):
  - RD: oe=1, addr=n+WIDTH.
  - WR: we=1, addr=n, di=dout (di is loaded from dout at the edge ending RD).
  - Then fill the last row: WIDTH char writes of 0x20, then WIDTH attr writes of the latched attr.
  - Total 4*(HEIGHT-1)*WIDTH + 2*WIDTH cycles. Then IDLE.
- oe and we are never high in the same cycle. Between operations both are 0.
- FSM states: IDLE, PUT_C, PUT_A, SCROLL_RD, SCROLL_WR, FILL. A mode register in FILL selects last-row fill or full clear. Address counter width is AW.

Test Plan (WIDTH=20, HEIGHT=15):
1. Reset, then send 0x41 with attr 0x1F -> cycle A+1: we, addr=0, di=0x41; A+2: we, addr=300, di=0x1F; cursor (col 1, row 0); in_ready high at A+3.
2. Send 20 printable bytes from (0,0) -> 20th char written at addr 19/319; cursor becomes (0,1). Then 0x0D and 0x08 at col 0 -> cursor stays (0,1), no we/oe pulses.
3. Preload the buffer with distinct values, cursor at (5,14), send 0x0A -> busy for exactly 1160 cycles. Afterwards char[n]=old char[n+20] and attr[300+n]=old attr[320+n] for n<280; addr 280..299 = 0x20; addr 580..599 = latched attr; cursor (0,14).
4. Send 0x0C with attr 0x07 -> 600 consecutive we pulses; addr 0..299 di=0x20, addr 300..599 di=0x07; cursor (0,0); in_ready low throughout.
5. Assert reset midway through a scroll -> we/oe/busy drop to 0 asynchronously; cursor (0,0); after release in_ready=1 and the next byte is written at addr 0.
6. Hold in_valid high with back-to-back bytes -> each byte is accepted only when in_ready is high, none lost or duplicated; the bus never shows we and oe high together.
